// File: rtl/bayer_frame_sequencer.sv
// bayer_frame_sequencer
// Walks a raw Bayer frame in raster order. For each pixel it fetches the
// edge-clamped 3x3 neighbourhood one byte per cycle, then holds the packed
// matrix and Bayer region on the ALU while alu_start is high. Once alu_done
// is seen it writes the grey result back, one write per pixel.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   go, busy, frame_done   decoder handshake (go is sampled only in IDLE)
//   rd_en, rd_addr,        source memory; rd_data is valid one cycle
//   rd_data                after rd_en
//   alu_matrix, alu_region ALU operands; byte (ky,kx) at [40*ky+8*kx +:8]
//   alu_start, alu_done,   ALU handshake; dropping alu_start clears the ALU
//   alu_result
//   wr_en, wr_addr,        destination buffer write port
//   wr_data
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for go
// FETCH   | issue reads k=0..8, capture byte k-1 from the previous read
// CAPTURE | capture byte 8, raise alu_start
// RUN     | hold matrix/region until alu_done, then latch alu_result
// WRITE   | single write strobe, advance x/y
// DONE    | frame_done pulse, back to IDLE
module bayer_frame_sequencer #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   output logic              busy,
   output logic              frame_done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [199:0]      alu_matrix,
   output logic [1:0]        alu_region,
   output logic              alu_start,
   input  logic              alu_done,
   input  logic [7:0]        alu_result,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);

   localparam int XW = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CAPTURE, S_RUN, S_WRITE, S_DONE
   } state_t;

   state_t          state;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic [3:0]      k;
   logic [7:0]      nb [0:8];
   logic            last_x, last_y;

   assign last_x = (x == XW'(WIDTH - 1));
   assign last_y = (y == YW'(HEIGHT - 1));

   // Coordinates are clamped before the multiply, so the address can never
   // leave the frame.
   function automatic logic [ADDR_W-1:0] fetch_addr(input logic [XW-1:0] px,
                                                     input logic [YW-1:0] py,
                                                     input logic [3:0]    kk);
      logic [3:0]  kx, ky;
      logic [31:0] cx, cy;
      ky = kk / 4'd3;
      kx = kk % 4'd3;
      cx = 32'(px);
      cy = 32'(py);
      if (kx == 4'd0 && px != '0)                     cx = cx - 32'd1;
      else if (kx == 4'd2 && px != XW'(WIDTH - 1))    cx = cx + 32'd1;
      if (ky == 4'd0 && py != '0)                     cy = cy - 32'd1;
      else if (ky == 4'd2 && py != YW'(HEIGHT - 1))   cy = cy + 32'd1;
      return ADDR_W'(cy * 32'(WIDTH) + cx);
   endfunction

   // Bytes outside the 3x3 are hard-wired to zero.
   always_comb begin
      alu_matrix = '0;
      for (int ky = 0; ky < 3; ky++)
         for (int kx = 0; kx < 3; kx++)
            alu_matrix[40*ky + 8*kx +: 8] = nb[3*ky + kx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         alu_region <= '0;
         alu_start  <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         x          <= '0;
         y          <= '0;
         k          <= '0;
         for (int i = 0; i < 9; i++) nb[i] <= '0;
      end else begin
         frame_done <= 1'b0;
         wr_en      <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (go) begin
                  state   <= S_FETCH;
                  busy    <= 1'b1;
                  x       <= '0;
                  y       <= '0;
                  k       <= '0;
                  rd_en   <= 1'b1;
                  rd_addr <= fetch_addr('0, '0, 4'd0);
               end
            end
            S_FETCH: begin
               if (k != 4'd0) nb[k - 4'd1] <= rd_data;
               if (k == 4'd8) begin
                  rd_en <= 1'b0;
                  state <= S_CAPTURE;
               end else begin
                  k       <= k + 4'd1;
                  rd_addr <= fetch_addr(x, y, k + 4'd1);
               end
            end
            S_CAPTURE: begin
               nb[8]      <= rd_data;
               alu_region <= {y[0], x[0]};
               alu_start  <= 1'b1;
               state      <= S_RUN;
            end
            S_RUN: begin
               if (alu_done) begin
                  wr_data   <= alu_result;
                  alu_start <= 1'b0;
                  wr_en     <= 1'b1;
                  wr_addr   <= ADDR_W'(32'(y) * 32'(WIDTH) + 32'(x));
                  state     <= S_WRITE;
               end
            end
            S_WRITE: begin
               k <= '0;
               if (last_x && last_y) begin
                  x          <= '0;
                  y          <= '0;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  rd_en <= 1'b1;
                  state <= S_FETCH;
                  if (last_x) begin
                     x       <= '0;
                     y       <= y + 1'b1;
                     rd_addr <= fetch_addr('0, y + 1'b1, 4'd0);
                  end else begin
                     x       <= x + 1'b1;
                     rd_addr <= fetch_addr(x + 1'b1, y, 4'd0);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
